// File: rtl/alu_exec_stage.sv
// Two-stage execute wrapper around an external combinational ALU: S1 holds the
// operands that drive the ALU, S2 captures its result for writeback.
module alu_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic [2:0]            in_ALUop,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_ALUop,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Zero,
    input  logic                  alu_Overflow,
    input  logic                  alu_CarryOut,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_Result,
    output logic [2:0]            out_flags,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [CNT_WIDTH-1:0]  ovf_count
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  s1_valid_reg, s1_valid_next;
    logic [DATA_WIDTH-1:0] s1_a_reg, s1_b_reg;
    logic [2:0]            s1_op_reg;
    logic [TAG_WIDTH-1:0]  s1_tag_reg;

    logic                  s2_valid_reg, s2_valid_next;
    logic [DATA_WIDTH-1:0] s2_result_reg;
    logic [2:0]            s2_flags_reg;
    logic [2:0]            s2_op_reg;
    logic [TAG_WIDTH-1:0]  s2_tag_reg;

    logic [CNT_WIDTH-1:0]  ovf_count_reg;

    logic s2_free, s1_adv, accept, retire, ovf_hit;

    assign s2_free  = !s2_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_free;
    assign in_ready = !s1_valid_reg || s2_free;
    assign accept   = in_valid && in_ready;
    assign retire   = s2_valid_reg && out_ready;
    // Only arithmetic ops report a meaningful signed overflow.
    assign ovf_hit  = retire && s2_flags_reg[2] &&
                      ((s2_op_reg == OP_ADD) || (s2_op_reg == OP_SUB));

    always_comb begin
        s1_valid_next = s1_valid_reg;
        s2_valid_next = s2_valid_reg;
        if (accept) begin
            s1_valid_next = 1'b1;
        end else if (s1_adv) begin
            s1_valid_next = 1'b0;
        end
        // A load into S2 wins over a same-cycle retire.
        if (s1_adv) begin
            s2_valid_next = 1'b1;
        end else if (out_ready) begin
            s2_valid_next = 1'b0;
        end
        if (flush) begin
            s1_valid_next = 1'b0;
            s2_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_op_reg     <= '0;
            s1_tag_reg    <= '0;
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_flags_reg  <= '0;
            s2_op_reg     <= '0;
            s2_tag_reg    <= '0;
            ovf_count_reg <= '0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
            // Data registers may go stale under flush; only the valid bits matter.
            if (accept) begin
                s1_a_reg   <= in_A;
                s1_b_reg   <= in_B;
                s1_op_reg  <= in_ALUop;
                s1_tag_reg <= in_tag;
            end
            if (s1_adv) begin
                s2_result_reg <= alu_Result;
                s2_flags_reg  <= {alu_Overflow, alu_CarryOut, alu_Zero};
                s2_op_reg     <= s1_op_reg;
                s2_tag_reg    <= s1_tag_reg;
            end
            if (ovf_hit && !(&ovf_count_reg)) begin
                ovf_count_reg <= ovf_count_reg + CNT_ONE;
            end
        end
    end

    assign alu_A      = s1_a_reg;
    assign alu_B      = s1_b_reg;
    assign alu_ALUop  = s1_op_reg;
    assign out_valid  = s2_valid_reg;
    assign out_Result = s2_result_reg;
    assign out_flags  = s2_flags_reg;
    assign out_tag    = s2_tag_reg;
    assign ovf_count  = ovf_count_reg;

endmodule
